snake_body_reader: RTL and testbench
====================================

Name: snake_body_reader

Overview:
- Read-side companion to the snake head/move controller.
- The controller pushes each new head position {x,y} once per move. This block keeps the last N positions as the snake body in an internal ring buffer and retires the tail when the snake did not eat.
- The retired tail position is reported so the display can erase it.
- A sequential scan answers "is cell (qx,qy) occupied?" for both self-collision checks and food placement.

Parameters:
- MAX_LEN, 16: ring buffer depth, i.e. the maximum snake length. Must be a power of 2.
- COORD_W, 4: width of each of the x and y coordinates.
- PTR_W, $clog2(MAX_LEN): pointer width. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- push_valid  in  1  new head position offered this cycle
- push_ready  out  1  high when state==IDLE; a push is accepted when push_valid && push_ready
- push_x  in  COORD_W  head x
- push_y  in  COORD_W  head y
- grow  in  1  sampled with an accepted push; snake ate, so the tail is not retired
- query_start  in  1  request an occupancy scan
- query_x  in  COORD_W  cell x to test
- query_y  in  COORD_W  cell y to test
- busy  out  1  scan in progress (state != IDLE)
- done  out  1  one-cycle pulse; the scan result is valid
- hit  out  1  the queried cell is occupied; held until the next accepted query
- tail_valid  out  1  one-cycle pulse; a tail was retired
- tail_x  out  COORD_W  x of the retired tail; held between pulses
- tail_y  out  COORD_W  y of the retired tail; held between pulses
- length  out  PTR_W+1  current segment count, range 0..MAX_LEN
- full  out  1  length==MAX_LEN

Behaviour:
- Reset (reset low, async):
  - wr_ptr=0, rd_ptr=0, length=0, state=IDLE.
  - Outputs: done=0, hit=0, tail_valid=0, tail_x=0, tail_y=0, full=0.
  - Buffer contents are don't-care.
- Reset mid-scan aborts the scan with no done pulse.
- Storage: mem[MAX_LEN] holds {x,y}. Head is mem[wr_ptr-1], tail is mem[rd_ptr]. Pointers wrap modulo MAX_LEN.
- Accepted push, with results registered and visible next cycle:
  - Write {push_x,push_y} to mem[wr_ptr]; wr_ptr++.
  - length==0: length=1, no tail retire, grow ignored.
  - grow && !full: length++, no retire.
  - Otherwise (!grow, or grow while full): retire the tail.
    - tail_x/tail_y <= mem[rd_ptr] (read of the old tail, before the overwrite).
    - rd_ptr++; tail_valid=1 for one cycle; length unchanged.
    - Grow while full saturates silently; full stays 1.
- Query handshake:
  - A query is accepted when state==IDLE && query_start && !push_valid.
  - A push in the same cycle wins; query_start is dropped and the requester must retry.
  - On acceptance, latch query_x/query_y, clear hit, idx=0.
- Query FSM:
  - IDLE: on an accepted query, go to DONE if length==0, else go to SCAN.
  - SCAN: compare mem[rd_ptr+idx] with the latched query, one entry per cycle, idx counting 0..length-1 from the tail.
    - Match: hit=1, go to DONE (early exit).
    - idx==length-1 with no match: go to DONE with hit=0.
    - Otherwise idx++.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Scan latency, with the acceptance cycle as cycle 0:
  - Entry k compared in cycle k+1.
  - Match at entry k: done in cycle k+2.
  - No match: done in cycle length+1.
  - length==0: done in cycle 1.
- No pushes are accepted while busy, so the scan sees a stable snapshot.
- The scan covers every segment including the head. For self-collision, the requester queries the next head position before pushing it.

Decomposition:
- Shared package snake_pkg holds:
  - COORD_W, MAX_LEN
  - typedef pos_t {x,y}
  - typedef state enum {IDLE, SCAN, DONE}
- One natural sub-module: snake_body_ram. It is a MAX_LEN x 2*COORD_W memory with one write port and two async read ports (tail read, scan read).
- Pointers, length and the FSM stay in the top level.

Test Plan:
- Reset, then push (3,4) with grow=0 → length=1, tail_valid never pulses, push_ready=1.
- Push (1,1)g=1, (2,1)g=1, (3,1)g=0 → after the third push: tail_valid pulse, tail=(1,1), length=2.
- Body [(2,1),(3,1)]:
  - Query (3,1) → done in cycle 3, hit=1.
  - Query (7,7) → done in cycle 3, hit=0.
  - busy is high throughout each scan.
- Fill to 16 with grow=1, then push (5,5) with grow=1 → length stays 16, full=1, tail_valid pulses with the oldest entry; 20 further non-grow pushes wrap the pointers and the scan still finds the newest 16 only.
- Simultaneous events:
  - push_valid and query_start in the same IDLE cycle → push accepted, no scan (busy stays 0).
  - push_valid during SCAN → push_ready=0, the push is not accepted, and length is unchanged until IDLE.
- Drop reset low in the middle of a scan of length 8 → no done pulse, length=0, hit=0. After release, a query on empty gives done in cycle 1 with hit=0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and default sizing for the snake body tracking blocks.
package snake_pkg;

    localparam int unsigned COORD_W = 4;
    localparam int unsigned MAX_LEN = 16;

    // One board cell; x occupies the upper half so {x,y} concatenation order is preserved.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/snake_body_ram.sv
// Body position store: one synchronous write port, two asynchronous read ports (tail and scan).
module snake_body_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] tailAddr,
    output logic [DATA_W-1:0] tailData,
    input  logic [ADDR_W-1:0] scanAddr,
    output logic [DATA_W-1:0] scanData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign tailData = mem[tailAddr];
    assign scanData = mem[scanAddr];

endmodule

// File: rtl/snake_body_reader.sv
// Snake body ring buffer: accepts head pushes, retires/reports the tail, and
// answers cell-occupancy queries with a one-entry-per-cycle scan from the tail.
module snake_body_reader #(
    parameter  int unsigned MAX_LEN = snake_pkg::MAX_LEN,
    parameter  int unsigned COORD_W = snake_pkg::COORD_W,
    localparam int unsigned PTR_W   = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [COORD_W-1:0] push_x,
    input  logic [COORD_W-1:0] push_y,
    input  logic               grow,
    input  logic               query_start,
    input  logic [COORD_W-1:0] query_x,
    input  logic [COORD_W-1:0] query_y,
    output logic               busy,
    output logic               done,
    output logic               hit,
    output logic               tail_valid,
    output logic [COORD_W-1:0] tail_x,
    output logic [COORD_W-1:0] tail_y,
    output logic [PTR_W:0]     length,
    output logic               full
);

    import snake_pkg::*;

    state_t           state;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] idx;
    pos_t             qPos;
    pos_t             tailRd;
    pos_t             scanRd;
    logic             pushFire;
    logic             queryFire;
    logic             scanMatch;
    logic             scanLast;

    // A push offered in the same cycle as a query wins; the query is simply dropped.
    assign pushFire  = push_valid && push_ready;
    assign queryFire = (state == IDLE) && query_start && !push_valid;
    assign scanMatch = (scanRd == qPos);
    assign scanLast  = ({1'b0, idx} == (length - (PTR_W+1)'(1)));

    snake_body_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (PTR_W),
        .DATA_W (2*COORD_W)
    ) uRam (
        .clk      (clk),
        .wrEn     (pushFire),
        .wrAddr   (wrPtr),
        .wrData   ({push_x, push_y}),
        .tailAddr (rdPtr),
        .tailData (tailRd),
        .scanAddr (rdPtr + idx),
        .scanData (scanRd)
    );

    // Pointers, length, tail report and the query FSM; every output is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wrPtr      <= '0;
            rdPtr      <= '0;
            idx        <= '0;
            length     <= '0;
            full       <= 1'b0;
            qPos       <= '0;
            push_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit        <= 1'b0;
            tail_valid <= 1'b0;
            tail_x     <= '0;
            tail_y     <= '0;
        end else begin
            done       <= 1'b0;
            tail_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pushFire) begin
                        wrPtr <= wrPtr + PTR_W'(1);
                        if (length == '0) begin
                            length <= (PTR_W+1)'(1);
                        end else if (grow && !full) begin
                            length <= length + (PTR_W+1)'(1);
                            full   <= (length == (PTR_W+1)'(MAX_LEN - 1));
                        end else begin
                            // Growing while full saturates: the tail is retired as usual.
                            tail_x     <= tailRd.x;
                            tail_y     <= tailRd.y;
                            rdPtr      <= rdPtr + PTR_W'(1);
                            tail_valid <= 1'b1;
                        end
                    end else if (queryFire) begin
                        qPos       <= {query_x, query_y};
                        hit        <= 1'b0;
                        idx        <= '0;
                        busy       <= 1'b1;
                        push_ready <= 1'b0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (scanMatch) begin
                        hit   <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (scanLast) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + PTR_W'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    push_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    push_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_reader.sv
// Directed + randomized bench for snake_body_reader against a queue-based body model.
module tb_snake_body_reader;

    localparam int MAX_LEN = 16;
    localparam int COORD_W = 4;
    localparam int PTR_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               push_valid;
    logic               push_ready;
    logic [COORD_W-1:0] push_x;
    logic [COORD_W-1:0] push_y;
    logic               grow;
    logic               query_start;
    logic [COORD_W-1:0] query_x;
    logic [COORD_W-1:0] query_y;
    logic               busy;
    logic               done;
    logic               hit;
    logic               tail_valid;
    logic [COORD_W-1:0] tail_x;
    logic [COORD_W-1:0] tail_y;
    logic [PTR_W:0]     length;
    logic               full;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] body[$];
    logic [7:0] lastTail = 8'h00;

    snake_body_reader #(.MAX_LEN(MAX_LEN), .COORD_W(COORD_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_x      (push_x),
        .push_y      (push_y),
        .grow        (grow),
        .query_start (query_start),
        .query_x     (query_x),
        .query_y     (query_y),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .tail_valid  (tail_valid),
        .tail_x      (tail_x),
        .tail_y      (tail_y),
        .length      (length),
        .full        (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snake rules: first segment just appears, growth appends, otherwise the oldest drops off.
    function automatic logic modelPush(input logic [7:0] p, input logic g);
        logic tv;
        tv = 1'b0;
        if (body.size() == 0) begin
            body.push_back(p);
        end else if (g && body.size() < MAX_LEN) begin
            body.push_back(p);
        end else begin
            lastTail = body.pop_front();
            body.push_back(p);
            tv = 1'b1;
        end
        return tv;
    endfunction

    function automatic logic [7:0] absentPos();
        logic [7:0] p;
        for (int v = 0; v < 256; v++) begin
            p = 8'(v);
            if (!(p inside {body})) return p;
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] randPos();
        return 8'($urandom_range(255, 0));
    endfunction

    task automatic applyReset();
        reset = 1'b0;
        tick();
        body.delete();
        lastTail = 8'h00;
        reset = 1'b1;
        tick();
    endtask

    task automatic checkSnapshot(input string tag);
        check({tag, "_len"}, 32'(length), 32'(body.size()));
        check({tag, "_full"}, 32'(full), 32'(body.size() == MAX_LEN));
        check({tag, "_tail"}, 32'({tail_x, tail_y}), 32'(lastTail));
    endtask

    task automatic doPush(input logic [7:0] p, input logic g);
        logic expTv;
        check("push_ready", 32'(push_ready), 32'(1));
        {push_x, push_y} = p;
        grow = g;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        grow = 1'b0;
        expTv = modelPush(p, g);
        check("tail_valid", 32'(tail_valid), 32'(expTv));
        checkSnapshot("push");
        tick();
        check("tail_pulse_end", 32'(tail_valid), 32'(0));
    endtask

    task automatic doQuery(input logic [7:0] q);
        int   expCyc;
        logic expHit;
        int   c;
        logic seen;
        expHit = 1'b0;
        expCyc = body.size() + 1;
        for (int i = 0; i < body.size(); i++) begin
            if (!expHit && body[i] == q) begin
                expHit = 1'b1;
                expCyc = i + 2;
            end
        end
        if (body.size() == 0) expCyc = 1;
        check("q_ready", 32'(push_ready), 32'(1));
        {query_x, query_y} = q;
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        c = 1;
        seen = 1'b0;
        while (!seen && c <= MAX_LEN + 4) begin
            check("q_busy", 32'(busy), 32'(1));
            if (done === 1'b1) seen = 1'b1;
            else begin
                tick();
                c++;
            end
        end
        check("q_done_seen", 32'(seen), 32'(1));
        check("q_latency", 32'(c), 32'(expCyc));
        check("q_hit", 32'(hit), 32'(expHit));
        tick();
        check("q_done_pulse", 32'(done), 32'(0));
        check("q_idle", 32'(busy), 32'(0));
        check("q_hit_held", 32'(hit), 32'(expHit));
    endtask

    initial begin
        int         c;
        logic       seen;
        logic       tv;
        logic [7:0] p;

        reset = 1'b0;
        push_valid = 1'b0;
        push_x = '0;
        push_y = '0;
        grow = 1'b0;
        query_start = 1'b0;
        query_x = '0;
        query_y = '0;
        tick();
        tick();
        check("rst_len", 32'(length), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_hit", 32'(hit), 32'(0));
        check("rst_tv", 32'(tail_valid), 32'(0));
        check("rst_tail", 32'({tail_x, tail_y}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(push_ready), 32'(1));
        reset = 1'b1;
        tick();

        // First push on an empty body never retires.
        doPush(8'h34, 1'b0);
        applyReset();

        doPush(8'h11, 1'b1);
        doPush(8'h21, 1'b1);
        doPush(8'h31, 1'b0);
        check("plan_tail", 32'({tail_x, tail_y}), 32'(8'h11));
        check("plan_len", 32'(length), 32'(2));
        doQuery(8'h31);
        doQuery(8'h77);

        // Fill to capacity, saturate, then wrap the pointers.
        for (int i = 0; i < 14; i++) doPush(randPos(), 1'b1);
        check("fill_full", 32'(full), 32'(1));
        doPush(8'h55, 1'b1);
        for (int i = 0; i < 20; i++) doPush(randPos(), 1'b0);
        doQuery(body[MAX_LEN-1]);
        doQuery(body[0]);
        doQuery(body[7]);
        doQuery(lastTail);
        doQuery(absentPos());

        // Push and query in the same idle cycle: the push wins.
        p = randPos();
        {push_x, push_y} = p;
        grow = 1'b0;
        push_valid = 1'b1;
        {query_x, query_y} = body[3];
        query_start = 1'b1;
        tick();
        push_valid = 1'b0;
        query_start = 1'b0;
        tv = modelPush(p, 1'b0);
        check("race_busy", 32'(busy), 32'(0));
        check("race_tv", 32'(tail_valid), 32'(tv));
        checkSnapshot("race");
        tick();
        check("race_busy2", 32'(busy), 32'(0));
        check("race_done", 32'(done), 32'(0));

        // Push held during a full-length miss scan must stall.
        {query_x, query_y} = absentPos();
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        push_valid = 1'b1;
        {push_x, push_y} = randPos();
        c = 1;
        seen = 1'b0;
        while (!seen && c <= MAX_LEN + 4) begin
            check("stall_ready", 32'(push_ready), 32'(0));
            check("stall_len", 32'(length), 32'(body.size()));
            if (done === 1'b1) seen = 1'b1;
            else begin
                tick();
                c++;
            end
        end
        push_valid = 1'b0;
        check("stall_done_seen", 32'(seen), 32'(1));
        check("stall_latency", 32'(c), 32'(body.size() + 1));
        check("stall_hit", 32'(hit), 32'(0));
        tick();
        check("stall_tv", 32'(tail_valid), 32'(0));
        checkSnapshot("stall");

        // Randomized mix of pushes and queries from an empty body.
        applyReset();
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(9, 0) < 7) begin
                doPush(randPos(), ($urandom_range(2, 0) == 0));
            end else if (body.size() != 0 && $urandom_range(1, 0) == 1) begin
                doQuery(body[$urandom_range(body.size() - 1, 0)]);
            end else begin
                doQuery(randPos());
            end
        end

        // Reset in the middle of a length-8 scan aborts it silently.
        applyReset();
        for (int i = 0; i < 8; i++) doPush(8'(8'h90 + 8'(i)), 1'b1);
        {query_x, query_y} = body[7];
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'(0));
        check("abort_len", 32'(length), 32'(0));
        check("abort_hit", 32'(hit), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'(0));
        end
        body.delete();
        lastTail = 8'h00;
        reset = 1'b1;
        tick();
        doQuery(randPos());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
